// File: rtl/shared_bus_mux_pkg.sv
// Shared selection type used by the token-ring controllers, the arbiter and the bus mux.
package shared_bus_mux_pkg;

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_X = 2'd3
  } sel_t;

  localparam logic [1:0] A_ID = 2'd0;
  localparam logic [1:0] B_ID = 2'd1;
  localparam logic [1:0] C_ID = 2'd2;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/shared_bus_mux_hold_timer.sv
// Saturating hold counter with a sticky expiry flag, set on the edge the count reaches MAX_HOLD.
module hold_timer #(
  parameter int MAX_HOLD = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_HOLD);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LIMIT - 1'b1) expired <= 1'b1;
    end
  end

endmodule

// File: rtl/shared_bus_mux.sv
// Turns the three controller acks into ownership of one shared bus, registers the owner's
// word onto it, counts grants and flags overlapping acks and over-long holds.
module shared_bus_mux
  import shared_bus_mux_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ackA,
  input  logic              ackB,
  input  logic              ackC,
  input  logic [DATA_W-1:0] dataA,
  input  logic [DATA_W-1:0] dataB,
  input  logic [DATA_W-1:0] dataC,
  output logic [1:0]        owner,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic [CNT_W-1:0]  grant_count,
  output logic              overlap_err,
  output logic              hold_timeout
);

  sel_t              owner_q;
  sel_t              owner_d;
  logic [DATA_W-1:0] data_d;
  logic [1:0]        n_acks;
  logic              own_ack;
  logic              grant;
  logic              retained;

  // An owner keeps the bus as long as its own ack stays high; intruders never displace it.
  always_comb begin
    n_acks = popcount3({ackC, ackB, ackA});
    case (owner_q)
      SEL_A:   own_ack = ackA;
      SEL_B:   own_ack = ackB;
      SEL_C:   own_ack = ackC;
      default: own_ack = 1'b0;
    endcase

    owner_d = SEL_X;
    if (own_ack) begin
      owner_d = owner_q;
    end else if (n_acks == 2'd1) begin
      if (ackA)      owner_d = SEL_A;
      else if (ackB) owner_d = SEL_B;
      else           owner_d = SEL_C;
    end

    grant    = (owner_d != SEL_X) && (owner_d != owner_q);
    retained = (owner_d != SEL_X) && (owner_d == owner_q);

    case (owner_d)
      SEL_A:   data_d = dataA;
      SEL_B:   data_d = dataB;
      SEL_C:   data_d = dataC;
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= SEL_X;
      bus_valid   <= 1'b0;
      bus_data    <= '0;
      grant_count <= '0;
      overlap_err <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      bus_valid <= (owner_d != SEL_X);
      bus_data  <= data_d;
      if (grant)     grant_count <= grant_count + 1'b1;
      if (n_acks[1]) overlap_err <= 1'b1;
    end
  end

  always_comb begin
    owner = owner_q;
  end

  hold_timer #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!retained),
    .tick    (retained),
    .expired (hold_timeout)
  );

endmodule

// File: tb/tb_shared_bus_mux.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_shared_bus_mux;
  import shared_bus_mux_pkg::*;

  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ackA = 1'b0, ackB = 1'b0, ackC = 1'b0;
  logic [DATA_W-1:0] dataA = '0, dataB = '0, dataC = '0;
  logic [1:0]        owner;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic [CNT_W-1:0]  grant_count;
  logic              overlap_err;
  logic              hold_timeout;

  shared_bus_mux #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ackA(ackA), .ackB(ackB), .ackC(ackC),
    .dataA(dataA), .dataB(dataB), .dataC(dataC),
    .owner(owner), .bus_valid(bus_valid), .bus_data(bus_data),
    .grant_count(grant_count), .overlap_err(overlap_err), .hold_timeout(hold_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        owner;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cnt;
    logic              ovl;
    logic              hto;
    int                phase;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   phase  = 0;

  // Reference model: owner index 0..2 for A..C, 3 for a free bus.
  int                m_own  = 3;
  int                m_hold = 0;
  int                m_cnt  = 0;
  bit                m_ovl  = 1'b0;
  bit                m_hto  = 1'b0;
  logic [DATA_W-1:0] m_data = '0;

  function automatic logic [1:0] enc(input int id);
    case (id)
      0:       return SEL_A;
      1:       return SEL_B;
      2:       return SEL_C;
      default: return SEL_X;
    endcase
  endfunction

  task automatic model_step(input bit r, input bit a, input bit b, input bit c,
                            input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db,
                            input logic [DATA_W-1:0] dc);
    bit ak[3];
    int n, nxt;
    if (r) begin
      m_own = 3; m_hold = 0; m_cnt = 0; m_ovl = 1'b0; m_hto = 1'b0; m_data = '0;
      return;
    end
    ak[0] = a; ak[1] = b; ak[2] = c;
    n = int'(a) + int'(b) + int'(c);
    if (n >= 2) m_ovl = 1'b1;
    if (m_own != 3 && ak[m_own]) nxt = m_own;
    else if (n == 1)             nxt = a ? 0 : (b ? 1 : 2);
    else                         nxt = 3;
    if (nxt != 3 && nxt != m_own) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    if (nxt == 3 || nxt != m_own) begin
      m_hold = 0;
    end else begin
      if (m_hold < MAX_HOLD) m_hold++;
      if (m_hold == MAX_HOLD) m_hto = 1'b1;
    end
    m_own  = nxt;
    m_data = (nxt == 0) ? da : (nxt == 1) ? db : (nxt == 2) ? dc : '0;
  endtask

  task automatic drive(input bit r, input bit a, input bit b, input bit c,
                       input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db,
                       input logic [DATA_W-1:0] dc);
    exp_t e;
    @(negedge clk);
    rst = r; ackA = a; ackB = b; ackC = c; dataA = da; dataB = db; dataC = dc;
    model_step(r, a, b, c, da, db, dc);
    e.owner = enc(m_own);
    e.valid = (m_own != 3);
    e.data  = m_data;
    e.cnt   = CNT_W'(m_cnt);
    e.ovl   = m_ovl;
    e.hto   = m_hto;
    e.phase = phase;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int ph);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s phase=%0d t=%0t: got %0h expected %0h", name, ph, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("owner",        32'(owner),        32'(e.owner), e.phase);
        chk("bus_valid",    32'(bus_valid),    32'(e.valid), e.phase);
        chk("bus_data",     32'(bus_data),     32'(e.data),  e.phase);
        chk("grant_count",  32'(grant_count),  32'(e.cnt),   e.phase);
        chk("overlap_err",  32'(overlap_err),  32'(e.ovl),   e.phase);
        chk("hold_timeout", 32'(hold_timeout), 32'(e.hto),   e.phase);
      end
    end
  end

  initial begin : stimulus
    logic [2:0] acks;
    // 1: grant and release
    phase = 1;
    repeat (2) drive(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    repeat (3) drive(0, 1, 0, 0, 8'h5A, 8'h11, 8'h22);
    repeat (2) drive(0, 0, 0, 0, 8'h5A, 8'h11, 8'h22);
    // 2: direct handoff A -> B
    phase = 2;
    drive(0, 1, 0, 0, 8'h5A, 8'h00, 8'h00);
    repeat (2) drive(0, 0, 1, 0, 8'h5A, 8'hC3, 8'h00);
    drive(0, 0, 0, 0, 8'h00, 8'hC3, 8'h00);
    // 3: overlap from idle, flag sticky until reset
    phase = 3;
    repeat (2) drive(0, 1, 0, 1, 8'h01, 8'h02, 8'h03);
    repeat (3) drive(0, 0, 0, 0, 8'h01, 8'h02, 8'h03);
    drive(1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    // 4: hold timeout while B keeps the bus, data tracked every cycle
    phase = 4;
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 8'h00, 8'(8'h40 + i), 8'h00);
    repeat (2) drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    // 5: reset mid-grant, then five grants to wrap the counter
    phase = 5;
    repeat (2) drive(0, 0, 0, 1, 8'h00, 8'h00, 8'h77);
    drive(1, 0, 0, 1, 8'h00, 8'h00, 8'h77);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0, 8'(i), 8'h00, 8'h00);
      drive(0, 0, 0, 0, 8'(i), 8'h00, 8'h00);
    end
    // 6: randomized acks with sticky patterns and occasional reset
    phase = 6;
    acks = 3'b000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(5))
          0, 1:    acks = 3'b000;
          2, 3, 4: acks = 3'b001 << $urandom_range(2);
          default: acks = 3'($urandom_range(7));
        endcase
      end
      drive($urandom_range(49) == 0, acks[0], acks[1], acks[2],
            8'($urandom), 8'($urandom), 8'($urandom));
    end
    drive(0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
